// File: rtl/regfile_hilo.sv
// regfile_hilo -- architectural state at the write-back end of the pipeline.
//
// Holds the 32x32 GPR file (r0 hard-wired to zero, not stored) and the HI/LO
// pair, with two combinational read ports for ID-stage operand fetch and an
// optional same-cycle write-to-read bypass. A registered commit-trace port and
// a wrapping commit counter expose GPR commits for golden-trace comparison.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   rfwe/rfwa/rfwd      GPR write enable / address / data from WB
//   hilowe/hi_i/lo_i    HI/LO pair write enable / data from WB
//   rs_addr/rs_data     read port A
//   rt_addr/rt_data     read port B
//   hi_o/lo_o           current HI/LO (bypassed when WR_BYPASS != 0)
//   trace_valid/wa/wd   previous-cycle GPR commit (address/data always track)
//   commit_cnt          GPR commits since reset, modulo 2^CNT_W
module regfile_hilo #(
  parameter int unsigned WR_BYPASS = 1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rfwe,
  input  logic [4:0]       rfwa,
  input  logic [31:0]      rfwd,
  input  logic             hilowe,
  input  logic [31:0]      hi_i,
  input  logic [31:0]      lo_i,
  input  logic [4:0]       rs_addr,
  output logic [31:0]      rs_data,
  input  logic [4:0]       rt_addr,
  output logic [31:0]      rt_data,
  output logic [31:0]      hi_o,
  output logic [31:0]      lo_o,
  output logic             trace_valid,
  output logic [4:0]       trace_wa,
  output logic [31:0]      trace_wd,
  output logic [CNT_W-1:0] commit_cnt
);

  localparam logic BYP = (WR_BYPASS != 0);

  logic [31:0] gpr [1:31];
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        commit;

  // A write to r0 is not a commit: no array change, no trace, no count.
  assign commit = rfwe && (rfwa != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      gpr         <= '{default: '0};
      hi_q        <= '0;
      lo_q        <= '0;
      trace_valid <= 1'b0;
      trace_wa    <= '0;
      trace_wd    <= '0;
      commit_cnt  <= '0;
    end else begin
      if (commit) begin
        gpr[rfwa]  <= rfwd;
        commit_cnt <= commit_cnt + CNT_W'(1);
      end
      if (hilowe) begin
        hi_q <= hi_i;
        lo_q <= lo_i;
      end
      trace_valid <= commit;
      trace_wa    <= rfwa;
      trace_wd    <= rfwd;
    end
  end

  // Bypass is suppressed while rst is high since that write will be discarded;
  // the array itself is read unconditionally.
  always_comb begin
    rs_data = '0;
    if (rs_addr != '0) begin
      if (BYP && !rst && rfwe && (rfwa == rs_addr)) rs_data = rfwd;
      else                                         rs_data = gpr[rs_addr];
    end
  end

  always_comb begin
    rt_data = '0;
    if (rt_addr != '0) begin
      if (BYP && !rst && rfwe && (rfwa == rt_addr)) rt_data = rfwd;
      else                                         rt_data = gpr[rt_addr];
    end
  end

  always_comb begin
    hi_o = hi_q;
    lo_o = lo_q;
    if (BYP && !rst && hilowe) begin
      hi_o = hi_i;
      lo_o = lo_i;
    end
  end

endmodule
